// File: rtl/dircc_counter_recv_handler_pkg.sv
// Shared packages for the counter receive handler: system state flags, bus types,
// application state layout, and the handler's FSM encoding.
package dircc_system_states_pkg;
   localparam logic [31:0] DIRCC_STATE_STOPPED = 32'h0000_0001;
   localparam logic [31:0] DIRCC_STATE_DONE    = 32'h0000_0002;
endpackage

package dircc_types_pkg;
   typedef struct packed {
      logic [15:0] dest_id;
      logic [15:0] src_id;
      logic [31:0] payload;
   } packet_data_t;

   typedef struct packed {
      logic [31:0] dircc_state;
      logic [31:0] dircc_state_extra;
      logic [63:0] user_state;
   } device_state_t;
endpackage

package dircc_application_pkg;
   localparam logic [15:0] MAX_COUNT_DEFAULT = 16'd100;

   // Lower 32 bits of user_state; shared with the send handler.
   typedef struct packed {
      logic [15:0] rts;
      logic [15:0] count;
   } counter_state_t;

   typedef struct packed {
      logic [31:0] tick;
   } tick_msg_t;
endpackage

package dircc_counter_recv_handler_pkg;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_UPDATE = 2'd2,
      S_WRITE  = 2'd3
   } recv_state_t;
endpackage

// File: rtl/dircc_counter_recv_handler_if.sv
// Packet-in, state-read and state-write handshakes of the counter receive handler.
interface dircc_counter_recv_handler_if;
   import dircc_types_pkg::*;

   packet_data_t  packet_in;
   logic          packet_in_valid;
   logic          packet_in_ready;
   logic          state_read_req;
   device_state_t read_state;
   logic          read_state_valid;
   device_state_t write_state;
   logic          write_state_valid;
   logic          write_state_ready;

   // slave: the handler; master: the network interface and state store around it
   modport slave (
      input  packet_in, packet_in_valid, read_state, read_state_valid, write_state_ready,
      output packet_in_ready, state_read_req, write_state, write_state_valid
   );
   modport master (
      output packet_in, packet_in_valid, read_state, read_state_valid, write_state_ready,
      input  packet_in_ready, state_read_req, write_state, write_state_valid
   );
endinterface

// File: rtl/dircc_counter_recv_handler_update.sv
// Combinational UPDATE step: bumps count/rts, flags DONE at MAX_COUNT, decides drops.
// Stale-tick filtering is enabled by DIRCC_RECV_STALE_FILTER_EN.
module dircc_counter_update
   import dircc_system_states_pkg::*, dircc_types_pkg::*, dircc_application_pkg::*;
#(
   parameter logic [15:0] MAX_COUNT = MAX_COUNT_DEFAULT
) (
   input  device_state_t st,
   input  packet_data_t  pkt,
   output device_state_t st_new,
   output logic          drop
);
   counter_state_t cur, nxt;
   tick_msg_t      tick;
   logic           unused_bits;

   assign cur         = counter_state_t'(st.user_state[31:0]);
   assign tick        = tick_msg_t'(pkt.payload);
   assign unused_bits = ^{pkt, tick, st.user_state[63:32]};

   always_comb begin
      nxt.count = cur.count + 16'd1;
      nxt.rts   = (cur.rts == 16'hFFFF) ? cur.rts : cur.rts + 16'd1;
      st_new            = st;
      st_new.user_state = {32'h0, nxt};
      if (nxt.count == MAX_COUNT)
         st_new.dircc_state = st.dircc_state | DIRCC_STATE_DONE;
      drop = (|(st.dircc_state & DIRCC_STATE_STOPPED)) ||
             (|(st.dircc_state & DIRCC_STATE_DONE));
`ifdef DIRCC_RECV_STALE_FILTER_EN
      if (tick.tick[15:0] < cur.count)
         drop = 1'b1;
`endif
   end
endmodule

// File: rtl/dircc_counter_recv_handler.sv
// Counter receive handler: packet -> read device state -> update -> write back.
// DIRCC_RECV_STALE_FILTER_EN adds stale-tick dropping and the drop_count port.
module dircc_counter_recv_handler
   import dircc_types_pkg::*, dircc_application_pkg::*, dircc_counter_recv_handler_pkg::*;
#(
   parameter int          ADDRESS_MEM_WIDTH = 32,
   parameter logic [15:0] MAX_COUNT         = MAX_COUNT_DEFAULT
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [ADDRESS_MEM_WIDTH-1:0] address,
   dircc_counter_recv_handler_if.slave  bus
`ifdef DIRCC_RECV_STALE_FILTER_EN
   ,
   output logic [15:0]                  drop_count
`endif
);
   recv_state_t   state, state_nxt;
   packet_data_t  pkt_q;
   device_state_t st_q, st_new;
   logic          upd_drop;
   logic          unused_addr;

   assign unused_addr = ^address;

   dircc_counter_update #(.MAX_COUNT(MAX_COUNT)) u_update (
      .st     (st_q),
      .pkt    (pkt_q),
      .st_new (st_new),
      .drop   (upd_drop)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt             = state;
      bus.packet_in_ready   = 1'b0;
      bus.state_read_req    = 1'b0;
      bus.write_state_valid = 1'b0;
      case (state)
         S_IDLE: begin
            bus.packet_in_ready = 1'b1;
            if (bus.packet_in_valid) state_nxt = S_READ;
         end
         S_READ: begin
            bus.state_read_req = 1'b1;
            if (bus.read_state_valid) state_nxt = S_UPDATE;
         end
         S_UPDATE: state_nxt = upd_drop ? S_IDLE : S_WRITE;
         S_WRITE: begin
            bus.write_state_valid = 1'b1;
            if (bus.write_state_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // write_state only changes in UPDATE, so it is stable throughout WRITE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_q           <= '0;
         st_q            <= '0;
         bus.write_state <= '0;
      end else begin
         if (state == S_IDLE && bus.packet_in_valid)  pkt_q <= bus.packet_in;
         if (state == S_READ && bus.read_state_valid) st_q  <= bus.read_state;
         if (state == S_UPDATE && !upd_drop)          bus.write_state <= st_new;
      end
   end

`ifdef DIRCC_RECV_STALE_FILTER_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         drop_count <= '0;
      else if (state == S_UPDATE && upd_drop && drop_count != 16'hFFFF)
         drop_count <= drop_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_dircc_counter_recv_handler.sv
// Directed bench for dircc_counter_recv_handler; honours DIRCC_RECV_STALE_FILTER_EN.
module tb_dircc_counter_recv_handler;
   import dircc_types_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [31:0] address = 32'h0000_1000;
   int total = 0;
   int bad = 0;
`ifdef DIRCC_RECV_STALE_FILTER_EN
   logic [15:0] drop_count;
`endif

   dircc_counter_recv_handler_if bus ();

   dircc_counter_recv_handler #(.ADDRESS_MEM_WIDTH(32), .MAX_COUNT(16'd100)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .address (address),
      .bus     (bus.slave)
`ifdef DIRCC_RECV_STALE_FILTER_EN
      ,
      .drop_count (drop_count)
`endif
   );

   always #5 clk = ~clk;

   // Drives one packet (accepted at the current negedge = cycle N), returns the state
   // at N+2, and scans up to N+12 for a write. lat is the cycle offset of write_state_valid.
   task automatic run_txn(input device_state_t st, input logic [15:0] tick,
                          input logic early_rdy, input logic hold,
                          output int lat, output logic req_n1, output logic pir_n4,
                          output device_state_t wr);
      lat = -1; wr = '0; pir_n4 = 1'b0;
      bus.packet_in = '{dest_id:16'h0001, src_id:16'h0002, payload:{16'h0, tick}};
      bus.packet_in_valid = 1'b1;
      bus.write_state_ready = early_rdy;
      @(negedge clk);
      bus.packet_in_valid = 1'b0;
      bus.packet_in = '{dest_id:16'hFFFF, src_id:16'hFFFF, payload:32'h0000_FFFF};
      req_n1 = bus.state_read_req;
      @(negedge clk);
      bus.read_state = st;
      bus.read_state_valid = 1'b1;
      for (int k = 3; k <= 12; k++) begin
         @(negedge clk);
         bus.read_state_valid = 1'b0;
         bus.read_state = '0;
         if (k == 4) pir_n4 = bus.packet_in_ready;
         if (bus.write_state_valid) begin
            lat = k;
            wr = bus.write_state;
            if (!hold) begin
               bus.write_state_ready = 1'b1;
               @(negedge clk);
            end
            break;
         end
      end
      if (!hold) bus.write_state_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.packet_in = '0; bus.packet_in_valid = 1'b0;
      bus.read_state = '0; bus.read_state_valid = 1'b0;
      bus.write_state_ready = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      total++; if (bus.packet_in_ready !== 1'b1) begin bad++; $display("FAIL reset_pir got=%b want=1", bus.packet_in_ready); end
      total++; if (bus.state_read_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus.state_read_req); end
      total++; if (bus.write_state_valid !== 1'b0) begin bad++; $display("FAIL reset_wsv got=%b want=0", bus.write_state_valid); end
      total++; if (bus.write_state !== 128'h0) begin bad++; $display("FAIL reset_ws got=%h want=0", bus.write_state); end
`ifdef DIRCC_RECV_STALE_FILTER_EN
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_count); end
`endif
   endtask

   task automatic test_basic();
      int lat; logic req, pir; device_state_t wr;
      run_txn('{dircc_state:32'h0, dircc_state_extra:32'hA5A5_0001, user_state:64'h0000_0000_0000_0005},
              16'd5, 1'b0, 1'b0, lat, req, pir, wr);
      total++; if (req !== 1'b1) begin bad++; $display("FAIL basic_req_n1 got=%b want=1", req); end
      total++; if (lat !== 4) begin bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
      total++; if (wr !== {32'h0, 32'hA5A5_0001, 64'h0000_0000_0001_0006}) begin
         bad++; $display("FAIL basic_write got=%h want=%h", wr, {32'h0, 32'hA5A5_0001, 64'h0000_0000_0001_0006}); end
   endtask

   task automatic test_done();
      int lat; logic req, pir; device_state_t wr, wr2;
      run_txn('{dircc_state:32'h0, dircc_state_extra:32'h0, user_state:64'h0000_0000_0003_0063},
              16'd99, 1'b0, 1'b0, lat, req, pir, wr);
      total++; if (wr !== {32'h2, 32'h0, 64'h0000_0000_0004_0064}) begin
         bad++; $display("FAIL done_write got=%h want=%h", wr, {32'h2, 32'h0, 64'h0000_0000_0004_0064}); end
      run_txn(wr, 16'd100, 1'b0, 1'b0, lat, req, pir, wr2);
      total++; if (lat !== -1) begin bad++; $display("FAIL done_drop wsv_at=%0d want=none", lat); end
   endtask

   task automatic test_stopped();
      int lat; logic req, pir; device_state_t wr;
      run_txn('{dircc_state:32'h1, dircc_state_extra:32'h0, user_state:64'h0000_0000_0000_0007},
              16'd7, 1'b0, 1'b0, lat, req, pir, wr);
      total++; if (lat !== -1) begin bad++; $display("FAIL stopped_drop wsv_at=%0d want=none", lat); end
      total++; if (pir !== 1'b1) begin bad++; $display("FAIL stopped_pir_n4 got=%b want=1", pir); end
   endtask

   task automatic test_saturate();
      int lat; logic req, pir; device_state_t wr;
      run_txn('{dircc_state:32'h0, dircc_state_extra:32'h0, user_state:64'h0000_0000_FFFF_000A},
              16'd10, 1'b0, 1'b0, lat, req, pir, wr);
      total++; if (wr !== {32'h0, 32'h0, 64'h0000_0000_FFFF_000B}) begin
         bad++; $display("FAIL saturate_write got=%h want=%h", wr, {32'h0, 32'h0, 64'h0000_0000_FFFF_000B}); end
   endtask

   task automatic test_filter();
      int lat; logic req, pir; device_state_t wr;
      device_state_t st8 = '{dircc_state:32'h0, dircc_state_extra:32'h0, user_state:64'h0000_0000_0002_0008};
`ifdef DIRCC_RECV_STALE_FILTER_EN
      total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL filter_drop_before got=%0d want=2", drop_count); end
      run_txn(st8, 16'd3, 1'b0, 1'b0, lat, req, pir, wr);
      total++; if (lat !== -1) begin bad++; $display("FAIL filter_stale wsv_at=%0d want=none", lat); end
      total++; if (drop_count !== 16'd3) begin bad++; $display("FAIL filter_drop_after got=%0d want=3", drop_count); end
`else
      run_txn(st8, 16'd3, 1'b0, 1'b0, lat, req, pir, wr);
      total++; if (wr !== {32'h0, 32'h0, 64'h0000_0000_0003_0009}) begin
         bad++; $display("FAIL nofilter_old_tick got=%h want=%h", wr, {32'h0, 32'h0, 64'h0000_0000_0003_0009}); end
`endif
      run_txn(st8, 16'd8, 1'b0, 1'b0, lat, req, pir, wr);
      total++; if (wr !== {32'h0, 32'h0, 64'h0000_0000_0003_0009}) begin
         bad++; $display("FAIL filter_fresh got=%h want=%h", wr, {32'h0, 32'h0, 64'h0000_0000_0003_0009}); end
   endtask

   task automatic test_back_to_back();
      int lat; logic req, pir; device_state_t wr;
      // a stray read_state_valid while idle must not start a read
      bus.read_state_valid = 1'b1;
      @(negedge clk);
      bus.read_state_valid = 1'b0;
      total++; if (bus.packet_in_ready !== 1'b1 || bus.state_read_req !== 1'b0) begin
         bad++; $display("FAIL idle_rsv_ignored pir=%b req=%b want pir=1 req=0", bus.packet_in_ready, bus.state_read_req); end
      run_txn('{dircc_state:32'h0, dircc_state_extra:32'h77, user_state:64'h0},
              16'd0, 1'b1, 1'b0, lat, req, pir, wr);
      total++; if (lat !== 4) begin bad++; $display("FAIL b2b_early_ready_lat got=%0d want=4", lat); end
      total++; if (wr !== {32'h0, 32'h77, 64'h0000_0000_0001_0001}) begin
         bad++; $display("FAIL b2b_first got=%h want=%h", wr, {32'h0, 32'h77, 64'h0000_0000_0001_0001}); end
      total++; if (bus.packet_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_pir_m1 got=%b want=1", bus.packet_in_ready); end
      run_txn('{dircc_state:32'h0, dircc_state_extra:32'h0, user_state:64'h0000_0000_0010_0020},
              16'h20, 1'b0, 1'b0, lat, req, pir, wr);
      total++; if (lat !== 4 || wr !== {32'h0, 32'h0, 64'h0000_0000_0011_0021}) begin
         bad++; $display("FAIL b2b_second lat=%0d got=%h want lat=4 %h", lat, wr, {32'h0, 32'h0, 64'h0000_0000_0011_0021}); end
   endtask

   task automatic test_reset_mid();
      int lat; logic req, pir; device_state_t wr, wr2;
      logic stable = 1'b1;
      run_txn('{dircc_state:32'h0, dircc_state_extra:32'h0, user_state:64'h0000_0000_0000_0001},
              16'd1, 1'b0, 1'b1, lat, req, pir, wr);
      total++; if (wr !== {32'h0, 32'h0, 64'h0000_0000_0001_0002}) begin
         bad++; $display("FAIL held_write got=%h want=%h", wr, {32'h0, 32'h0, 64'h0000_0000_0001_0002}); end
      repeat (4) begin
         @(negedge clk);
         if (bus.write_state_valid !== 1'b1 || bus.write_state !== wr) stable = 1'b0;
      end
      total++; if (stable !== 1'b1) begin bad++; $display("FAIL held_stable got=%b want=1", stable); end
      reset_n = 1'b0;
      #1;
      total++; if (bus.write_state_valid !== 1'b0) begin bad++; $display("FAIL midreset_wsv got=%b want=0", bus.write_state_valid); end
      total++; if (bus.write_state !== 128'h0) begin bad++; $display("FAIL midreset_ws got=%h want=0", bus.write_state); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      total++; if (bus.packet_in_ready !== 1'b1) begin bad++; $display("FAIL postreset_pir got=%b want=1", bus.packet_in_ready); end
`ifdef DIRCC_RECV_STALE_FILTER_EN
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL postreset_drop got=%0d want=0", drop_count); end
`endif
      run_txn('{dircc_state:32'h0, dircc_state_extra:32'h0, user_state:64'h0000_0000_0005_0030},
              16'h30, 1'b0, 1'b0, lat, req, pir, wr2);
      total++; if (lat !== 4 || wr2 !== {32'h0, 32'h0, 64'h0000_0000_0006_0031}) begin
         bad++; $display("FAIL postreset_txn lat=%0d got=%h want lat=4 %h", lat, wr2, {32'h0, 32'h0, 64'h0000_0000_0006_0031}); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_done();
      test_stopped();
      test_saturate();
      test_filter();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dircc_counter_recv_handler.md
# dircc_counter_recv_handler

Receive-side handler for the counter application. Accepts incoming tick packets from the network interface, fetches the owning device's state, increments the count, and raises the ready-to-send counter. Writes the updated state back to the device-state store, where the counter send handler drains it. Sits directly upstream of the send handler, sharing the state store and the `user_state` layout `{rts[31:16], count[15:0]}`.

## Interface
- `ADDRESS_MEM_WIDTH`, 32: width of the device address bus.
- `MAX_COUNT`, 16'd100: count value at which the device is marked done.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  ADDRESS_MEM_WIDTH  device address; passed through, unused in logic.
- `packet_in`  in  packet_data_t  incoming tick packet; `tick[15:0]` is the sender's count.
- `packet_in_valid`  in  1  packet present.
- `packet_in_ready`  out  1  block can accept a packet.
- `state_read_req`  out  1  request the device state.
- `read_state`  in  device_state_t  state returned by the store.
- `read_state_valid`  in  1  `read_state` is valid this cycle.
- `write_state`  out  device_state_t  updated state.
- `write_state_valid`  out  1  write-back request.
- `write_state_ready`  in  1  store accepts the write.
- `drop_count`  out  16  packets discarded; present only with the filter macro.

## Operation
- FSM states:
  - IDLE: `packet_in_ready`=1. On `packet_in_valid`, capture `packet_in` into `pkt_q` and go to READ.
  - READ: `state_read_req`=1 and held. On `read_state_valid`, capture `read_state` into `st_q` and go to UPDATE.
  - UPDATE: compute the new state. On a drop, return to IDLE. Otherwise register `write_state` and go to WRITE.
  - WRITE: `write_state_valid`=1 and held. On `write_state_ready`, return to IDLE.
- Drop conditions (checked in UPDATE, in this order):
  - `dircc_state & DIRCC_STATE_STOPPED`
  - `dircc_state & DIRCC_STATE_DONE`
  - stale filter hit (see Configuration)
- A dropped packet produces no write and increments `drop_count` if present.
- Update arithmetic:
  - `count_new = count + 1`, 16-bit.
  - `rts_new = rts + 1`, saturating at 16'hFFFF.
  - If `count_new == MAX_COUNT`, `dircc_state_new = dircc_state | DIRCC_STATE_DONE`; otherwise `dircc_state` is unchanged.
  - `dircc_state_extra` passes through unchanged.
  - `user_state` is written as `{'0, rts_new, count_new}`.
- Only one packet is in flight; there is no pipelining across devices.
- Reset mid-operation aborts any transaction: the FSM returns to IDLE and no partial write is issued.

## Timing
- Reset values: FSM in IDLE, `packet_in_ready`=1 once reset is released, `state_read_req`=0, `write_state_valid`=0, `write_state`='0, `drop_count`=0.
- `packet_in_ready` and `state_read_req` are decoded from the FSM state.
- Minimum latency, with `read_state_valid` arriving the cycle after the request:
  - accept at N
  - `state_read_req` high at N+1
  - `read_state_valid` at N+2
  - UPDATE at N+3
  - `write_state_valid` at N+4
- After a write handshake at cycle M, the FSM is in IDLE at M+1 and the next packet can be accepted at M+1.
- The minimum cycle time per packet is 5 cycles.
- `write_state` is stable for as long as `write_state_valid` is high.
- `read_state_valid` is ignored outside READ.
- `packet_in` is ignored outside IDLE.
- `write_state_ready` asserted before `write_state_valid` is legal; the handshake completes on the first cycle both are high.

## Configuration
- Macro: `DIRCC_RECV_STALE_FILTER_EN`.
- Defined:
  - A packet with `tick[15:0] < count` is treated as stale and dropped.
  - `drop_count` exists and counts all drops. It saturates at 16'hFFFF.
- Undefined:
  - All packets not excluded by the STOPPED or DONE conditions are applied.
  - The `drop_count` port and its logic are absent.

## Structure
- `dircc_application_pkg` holds the counter state struct `counter_state_t {rts[15:0], count[15:0]}`, the tick message struct `tick_msg_t`, and the `MAX_COUNT` default. The send handler uses the same definitions.
- `DIRCC_STATE_*` constants stay in `dircc_system_states_pkg`.
- `packet_data_t` and `device_state_t` stay in `dircc_types_pkg`.
- Sub-module `dircc_counter_update`: the purely combinational UPDATE logic, taking `st_q` and `pkt_q` and producing the new state plus a drop flag. It is unit-testable on its own.

## Test plan
- State {rts=0, count=5}, one packet with tick=5, read returned 1 cycle after the request → write of {rts=1, count=6} at N+4, `dircc_state` unchanged.
- count=`MAX_COUNT`-1=99, packet arrives → write with count=100 and DONE set. A further packet then → no write (dropped).
- `dircc_state` has STOPPED set → no `write_state_valid`, FSM back in IDLE, `packet_in_ready`=1 the cycle after UPDATE.
- rts=16'hFFFF, count=10 → write with rts=16'hFFFF (saturated), count=11.
- Filter defined, count=8, tick=3 → dropped, `drop_count` 0→1. With tick=8 → applied, count=9.
- Hold `write_state_ready` low for 4 cycles, then assert `reset_n`=0 → `write_state_valid`=0 at once. After reset release, a new packet is accepted and processed normally.
